// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB plus a parallel untagged table of
// 2-bit saturating counters, indexed by pc[IDX_BITS+1:2].
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   if_pc             fetch PC; pred_taken / pred_target are combinational
//                     predictions for it
//   ex_valid/ex_stall a conditional branch resolves in EX; stall holds it
//   ex_pc, ex_br_en, ex_target              resolved branch information
//   ex_pred_taken, ex_pred_target           prediction carried with branch
//   mispredict, redirect_pc                 combinational flush request
//   stat_branches, stat_mispredicts         registered performance counters
module branch_predictor #(
  parameter int unsigned IDX_BITS = 6,
  parameter int unsigned TAG_BITS = 32 - IDX_BITS - 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        ex_valid,
  input  logic        ex_stall,
  input  logic [31:0] ex_pc,
  input  logic        ex_br_en,
  input  logic [31:0] ex_target,
  input  logic        ex_pred_taken,
  input  logic [31:0] ex_pred_target,
  output logic        mispredict,
  output logic [31:0] redirect_pc,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispredicts
);

  localparam int unsigned ENTRIES = 1 << IDX_BITS;

  logic                valid_q  [ENTRIES];
  logic [TAG_BITS-1:0] tag_q    [ENTRIES];
  logic [31:0]         target_q [ENTRIES];
  logic [1:0]          ctr_q    [ENTRIES];

  logic [IDX_BITS-1:0] if_idx;
  logic [IDX_BITS-1:0] ex_idx;
  logic [TAG_BITS-1:0] if_tag;
  logic [TAG_BITS-1:0] ex_tag;
  logic                hit;
  logic                upd;
  logic                unused_pc_bits;

  assign if_idx = if_pc[IDX_BITS+1:2];
  assign if_tag = if_pc[31:IDX_BITS+2];
  assign ex_idx = ex_pc[IDX_BITS+1:2];
  assign ex_tag = ex_pc[31:IDX_BITS+2];

  // Word-aligned PCs: the byte-offset bits carry no information here.
  assign unused_pc_bits = ^{if_pc[1:0], ex_pc[1:0]};

  // Training happens only for a resolved, unstalled branch outside reset.
  assign upd = ex_valid && !ex_stall && !rst;

  // Fetch-side prediction; reads pre-edge state, so no write bypass.
  always_comb begin
    hit         = 1'b0;
    pred_taken  = 1'b0;
    pred_target = if_pc + 32'd4;
    hit         = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    pred_taken  = hit && ctr_q[if_idx][1];
    if (pred_taken) begin
      pred_target = target_q[if_idx];
    end
  end

  // Flush request; stall gating of the flush belongs to the hazard unit.
  always_comb begin
    mispredict  = 1'b0;
    redirect_pc = ex_br_en ? ex_target : ex_pc + 32'd4;
    if (ex_valid) begin
      mispredict = (ex_br_en != ex_pred_taken) ||
                   (ex_br_en && (ex_pred_target != ex_target));
    end
  end

  // Valid bits and saturating counters; counters train on every branch.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= 2'b01;
      end
    end else if (upd) begin
      if (ex_br_en) begin
        valid_q[ex_idx] <= 1'b1;
        if (ctr_q[ex_idx] != 2'b11) begin
          ctr_q[ex_idx] <= ctr_q[ex_idx] + 2'd1;
        end
      end else if (ctr_q[ex_idx] != 2'b00) begin
        ctr_q[ex_idx] <= ctr_q[ex_idx] - 2'd1;
      end
    end
  end

  // Tag/target payload: only taken branches allocate, overwriting aliases.
  always_ff @(posedge clk) begin
    if (upd && ex_br_en) begin
      tag_q[ex_idx]    <= ex_tag;
      target_q[ex_idx] <= ex_target;
    end
  end

  // Performance counters, wrapping modulo 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_branches    <= 32'd0;
      stat_mispredicts <= 32'd0;
    end else if (upd) begin
      stat_branches <= stat_branches + 32'd1;
      if (mispredict) begin
        stat_mispredicts <= stat_mispredicts + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor (IDX_BITS = 6).
module tb_branch_predictor;

  logic        clk;
  logic        rst;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        ex_valid;
  logic        ex_stall;
  logic [31:0] ex_pc;
  logic        ex_br_en;
  logic [31:0] ex_target;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;

  branch_predictor dut (
    .clk              (clk),
    .rst              (rst),
    .if_pc            (if_pc),
    .pred_taken       (pred_taken),
    .pred_target      (pred_target),
    .ex_valid         (ex_valid),
    .ex_stall         (ex_stall),
    .ex_pc            (ex_pc),
    .ex_br_en         (ex_br_en),
    .ex_target        (ex_target),
    .ex_pred_taken    (ex_pred_taken),
    .ex_pred_target   (ex_pred_target),
    .mispredict       (mispredict),
    .redirect_pc      (redirect_pc),
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  int n_checks = 0;
  int n_pass   = 0;

  // Observed snapshot: {pred_taken, pred_target, mispredict, redirect_pc, stats}
  logic [129:0] obs;
  assign obs = {pred_taken, pred_target, mispredict, redirect_pc,
                stat_branches, stat_mispredicts};

  logic [129:0] sb_q [$];
  logic [129:0] exp_v;

  // Reference model state
  logic        m_valid [64];
  logic [23:0] m_tag   [64];
  logic [31:0] m_tgt   [64];
  logic [1:0]  m_ctr   [64];
  logic [31:0] m_sb;
  logic [31:0] m_sm;

  function automatic logic [129:0] model_exp();
    logic [5:0]  i;
    logic        pt;
    logic [31:0] pt_tgt;
    logic        mp;
    logic [31:0] rpc;
    i      = if_pc[7:2];
    pt     = m_valid[i] && (m_tag[i] == if_pc[31:8]) && m_ctr[i][1];
    pt_tgt = pt ? m_tgt[i] : if_pc + 32'd4;
    mp     = ex_valid && ((ex_br_en != ex_pred_taken) ||
                          (ex_br_en && (ex_pred_target != ex_target)));
    rpc    = ex_br_en ? ex_target : ex_pc + 32'd4;
    return {pt, pt_tgt, mp, rpc, m_sb, m_sm};
  endfunction

  // Advance one clock, updating the model with the inputs held at the edge.
  task automatic tick();
    logic [5:0] i;
    logic       mp;
    @(posedge clk);
    if (rst) begin
      for (int k = 0; k < 64; k++) begin
        m_valid[k] = 1'b0;
        m_ctr[k]   = 2'b01;
      end
      m_sb = 32'd0;
      m_sm = 32'd0;
    end else if (ex_valid && !ex_stall) begin
      i  = ex_pc[7:2];
      mp = (ex_br_en != ex_pred_taken) ||
           (ex_br_en && (ex_pred_target != ex_target));
      if (ex_br_en) begin
        m_valid[i] = 1'b1;
        m_tag[i]   = ex_pc[31:8];
        m_tgt[i]   = ex_target;
        if (m_ctr[i] != 2'b11) m_ctr[i] = m_ctr[i] + 2'd1;
      end else if (m_ctr[i] != 2'b00) begin
        m_ctr[i] = m_ctr[i] - 2'd1;
      end
      m_sb = m_sb + 32'd1;
      if (mp) m_sm = m_sm + 32'd1;
    end
    #1;
  endtask

  task automatic set_ex(input logic v, input logic s, input logic [31:0] pc,
                        input logic br, input logic [31:0] tgt,
                        input logic pt, input logic [31:0] ptgt);
    ex_valid       = v;
    ex_stall       = s;
    ex_pc          = pc;
    ex_br_en       = br;
    ex_target      = tgt;
    ex_pred_taken  = pt;
    ex_pred_target = ptgt;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_ex(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    if_pc = 32'h40;
    tick();
    tick();
    rst = 1'b0;
    sb_q.push_back(model_exp());
    @(negedge clk);
    exp_v = sb_q.pop_front();
    n_checks++; if (obs !== exp_v) $display("FAIL reset_snapshot got=%h exp=%h", obs, exp_v); else n_pass++;
    n_checks++; if (pred_taken !== 1'b0) $display("FAIL reset_pred_taken got=%b exp=0", pred_taken); else n_pass++;
    n_checks++; if (pred_target !== 32'h44) $display("FAIL reset_pred_target got=%h exp=00000044", pred_target); else n_pass++;
    n_checks++; if (stat_branches !== 32'd0 || stat_mispredicts !== 32'd0)
      $display("FAIL reset_stats got=%0d/%0d exp=0/0", stat_branches, stat_mispredicts); else n_pass++;
    // Fall-through must wrap at the top of the address space.
    if_pc = 32'hFFFF_FFFC;
    #1;
    n_checks++; if (pred_target !== 32'h0) $display("FAIL wrap_pred_target got=%h exp=00000000", pred_target); else n_pass++;
    tick();
  endtask

  task automatic test_idle();
    // ex_valid low: no flush and no state change despite a wrong-looking branch.
    set_ex(1'b0, 1'b0, 32'h40, 1'b1, 32'h80, 1'b0, 32'h44);
    if_pc = 32'h40;
    sb_q.push_back(model_exp());
    @(negedge clk);
    exp_v = sb_q.pop_front();
    n_checks++; if (obs !== exp_v) $display("FAIL idle_snapshot got=%h exp=%h", obs, exp_v); else n_pass++;
    n_checks++; if (mispredict !== 1'b0) $display("FAIL idle_mispredict got=%b exp=0", mispredict); else n_pass++;
    tick();
    @(negedge clk);
    n_checks++; if (pred_taken !== 1'b0 || stat_branches !== 32'd0)
      $display("FAIL idle_no_update got=%b/%0d exp=0/0", pred_taken, stat_branches); else n_pass++;
    tick();
  endtask

  task automatic test_first_taken();
    set_ex(1'b1, 1'b0, 32'h40, 1'b1, 32'h80, 1'b0, 32'h44);
    if_pc = 32'h40;
    sb_q.push_back(model_exp());
    @(negedge clk);
    exp_v = sb_q.pop_front();
    n_checks++; if (obs !== exp_v) $display("FAIL first_snapshot got=%h exp=%h", obs, exp_v); else n_pass++;
    n_checks++; if (mispredict !== 1'b1 || redirect_pc !== 32'h80)
      $display("FAIL first_mispredict got=%b/%h exp=1/00000080", mispredict, redirect_pc); else n_pass++;
    n_checks++; if (pred_taken !== 1'b0) $display("FAIL first_no_bypass got=%b exp=0", pred_taken); else n_pass++;
    tick();
    set_ex(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    sb_q.push_back(model_exp());
    @(negedge clk);
    exp_v = sb_q.pop_front();
    n_checks++; if (obs !== exp_v) $display("FAIL first_after got=%h exp=%h", obs, exp_v); else n_pass++;
    n_checks++; if (pred_taken !== 1'b1 || pred_target !== 32'h80)
      $display("FAIL first_predict got=%b/%h exp=1/00000080", pred_taken, pred_target); else n_pass++;
    n_checks++; if (stat_branches !== 32'd1 || stat_mispredicts !== 32'd1)
      $display("FAIL first_stats got=%0d/%0d exp=1/1", stat_branches, stat_mispredicts); else n_pass++;
    tick();
  endtask

  task automatic test_saturate();
    if_pc = 32'h40;
    for (int n = 0; n < 3; n++) begin
      set_ex(1'b1, 1'b0, 32'h40, 1'b1, 32'h80, 1'b1, 32'h80);
      sb_q.push_back(model_exp());
      @(negedge clk);
      exp_v = sb_q.pop_front();
      n_checks++; if (obs !== exp_v) $display("FAIL sat_taken_%0d got=%h exp=%h", n, obs, exp_v); else n_pass++;
      tick();
    end
    // Two not-taken: 11 -> 10 keeps predicting taken, 10 -> 01 stops.
    for (int n = 0; n < 2; n++) begin
      set_ex(1'b1, 1'b0, 32'h40, 1'b0, 32'h80, 1'b1, 32'h80);
      sb_q.push_back(model_exp());
      @(negedge clk);
      exp_v = sb_q.pop_front();
      n_checks++; if (obs !== exp_v) $display("FAIL sat_nt_%0d got=%h exp=%h", n, obs, exp_v); else n_pass++;
      n_checks++; if (mispredict !== 1'b1 || redirect_pc !== 32'h44)
        $display("FAIL sat_nt_redirect_%0d got=%b/%h exp=1/00000044", n, mispredict, redirect_pc); else n_pass++;
      tick();
      set_ex(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
      @(negedge clk);
      n_checks++; if (pred_taken !== (n == 0))
        $display("FAIL sat_nt_pred_%0d got=%b exp=%b", n, pred_taken, (n == 0)); else n_pass++;
      tick();
    end
    @(negedge clk);
    n_checks++; if (stat_branches !== 32'd6 || stat_mispredicts !== 32'd3)
      $display("FAIL sat_stats got=%0d/%0d exp=6/3", stat_branches, stat_mispredicts); else n_pass++;
    tick();
  endtask

  task automatic test_alias();
    set_ex(1'b1, 1'b0, 32'h140, 1'b1, 32'h200, 1'b0, 32'h144);
    if_pc = 32'h140;
    sb_q.push_back(model_exp());
    @(negedge clk);
    exp_v = sb_q.pop_front();
    n_checks++; if (obs !== exp_v) $display("FAIL alias_train got=%h exp=%h", obs, exp_v); else n_pass++;
    tick();
    set_ex(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    if_pc = 32'h40;
    sb_q.push_back(model_exp());
    @(negedge clk);
    exp_v = sb_q.pop_front();
    n_checks++; if (obs !== exp_v) $display("FAIL alias_old_snapshot got=%h exp=%h", obs, exp_v); else n_pass++;
    n_checks++; if (pred_taken !== 1'b0 || pred_target !== 32'h44)
      $display("FAIL alias_old_miss got=%b/%h exp=0/00000044", pred_taken, pred_target); else n_pass++;
    if_pc = 32'h140;
    #1;
    n_checks++; if (pred_taken !== 1'b1 || pred_target !== 32'h200)
      $display("FAIL alias_new_hit got=%b/%h exp=1/00000200", pred_taken, pred_target); else n_pass++;
    tick();
  endtask

  task automatic test_stall();
    if_pc = 32'h300;
    for (int n = 0; n < 4; n++) begin
      set_ex(1'b1, (n < 3), 32'h300, 1'b1, 32'h400, 1'b0, 32'h304);
      sb_q.push_back(model_exp());
      @(negedge clk);
      exp_v = sb_q.pop_front();
      n_checks++; if (obs !== exp_v) $display("FAIL stall_snapshot_%0d got=%h exp=%h", n, obs, exp_v); else n_pass++;
      n_checks++; if (mispredict !== 1'b1 || stat_branches !== 32'd7)
        $display("FAIL stall_hold_%0d got=%b/%0d exp=1/7", n, mispredict, stat_branches); else n_pass++;
      tick();
    end
    set_ex(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    n_checks++; if (stat_branches !== 32'd8 || stat_mispredicts !== 32'd5)
      $display("FAIL stall_stats got=%0d/%0d exp=8/5", stat_branches, stat_mispredicts); else n_pass++;
    tick();
    // One not-taken must drop the counter to 01 if it was trained exactly once.
    set_ex(1'b1, 1'b0, 32'h300, 1'b0, 32'h400, 1'b1, 32'h400);
    tick();
    set_ex(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    sb_q.push_back(model_exp());
    @(negedge clk);
    exp_v = sb_q.pop_front();
    n_checks++; if (obs !== exp_v) $display("FAIL stall_once_snapshot got=%h exp=%h", obs, exp_v); else n_pass++;
    n_checks++; if (pred_taken !== 1'b0) $display("FAIL stall_once_ctr got=%b exp=0", pred_taken); else n_pass++;
    tick();
  endtask

  task automatic test_target_mismatch();
    set_ex(1'b1, 1'b0, 32'h40, 1'b1, 32'h80, 1'b1, 32'h84);
    if_pc = 32'h40;
    sb_q.push_back(model_exp());
    @(negedge clk);
    exp_v = sb_q.pop_front();
    n_checks++; if (obs !== exp_v) $display("FAIL tgt_snapshot got=%h exp=%h", obs, exp_v); else n_pass++;
    n_checks++; if (mispredict !== 1'b1 || redirect_pc !== 32'h80)
      $display("FAIL tgt_mispredict got=%b/%h exp=1/00000080", mispredict, redirect_pc); else n_pass++;
    tick();
    set_ex(1'b1, 1'b0, 32'h40, 1'b1, 32'h80, 1'b1, 32'h80);
    sb_q.push_back(model_exp());
    @(negedge clk);
    exp_v = sb_q.pop_front();
    n_checks++; if (obs !== exp_v) $display("FAIL tgt_ok_snapshot got=%h exp=%h", obs, exp_v); else n_pass++;
    n_checks++; if (mispredict !== 1'b0) $display("FAIL tgt_ok_mispredict got=%b exp=0", mispredict); else n_pass++;
    tick();
    set_ex(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    n_checks++; if (stat_branches !== 32'd11 || stat_mispredicts !== 32'd7)
      $display("FAIL tgt_stats got=%0d/%0d exp=11/7", stat_branches, stat_mispredicts); else n_pass++;
    tick();
  endtask

  task automatic test_reset_collide();
    rst = 1'b1;
    set_ex(1'b1, 1'b0, 32'h80, 1'b1, 32'h100, 1'b0, 32'h84);
    tick();
    rst = 1'b0;
    set_ex(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    if_pc = 32'h80;
    sb_q.push_back(model_exp());
    @(negedge clk);
    exp_v = sb_q.pop_front();
    n_checks++; if (obs !== exp_v) $display("FAIL rstc_snapshot got=%h exp=%h", obs, exp_v); else n_pass++;
    n_checks++; if (pred_taken !== 1'b0 || pred_target !== 32'h84)
      $display("FAIL rstc_pred got=%b/%h exp=0/00000084", pred_taken, pred_target); else n_pass++;
    if_pc = 32'h40;
    #1;
    n_checks++; if (pred_taken !== 1'b0 || stat_branches !== 32'd0 || stat_mispredicts !== 32'd0)
      $display("FAIL rstc_state got=%b/%0d/%0d exp=0/0/0", pred_taken, stat_branches, stat_mispredicts); else n_pass++;
    tick();
  endtask

  initial begin
    rst   = 1'b1;
    if_pc = 32'h0;
    set_ex(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    test_reset();
    test_idle();
    test_first_taken();
    test_saturate();
    test_alias();
    test_stall();
    test_target_mismatch();
    test_reset_collide();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
